uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter between NUM_REQ byte requesters.
- Each requester has a valid/ready byte port; grants rotate round-robin.
- A requester keeps the grant for a multi-byte frame until it sends a byte with last=1.
- Sequences the transmitter with a start pulse and tracks its busy flag; sits between protocol/command engines and the single serial TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_pick.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter and its
// round-robin picker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3
  } uart_arb_state_t;

  // Bits needed to index n requesters; never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed for a timer that counts 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [idx_width(NUM_REQ)-1:0]  rr_ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [idx_width(NUM_REQ)-1:0]  grant_idx,
  output logic                           any
);

  localparam int IW = idx_width(NUM_REQ);
  localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

  logic [IW-1:0] ptr_eff;
  logic [IW-1:0] j_idx;
  int            j;

  // An out-of-range pointer (non-power-of-two counts) restarts the search at 0.
  assign ptr_eff = ({1'b0, rr_ptr} < NUM_REQ_W) ? rr_ptr : '0;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    j_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_eff) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IW'(j);
      if (!any && req[j_idx]) begin
        any          = 1'b1;
        grant[j_idx] = 1'b1;
        grant_idx    = j_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// requesters, with multi-byte frame locking and launch/acknowledge sequencing.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int data_bits      = 8,
  parameter int accept_timeout = 16,
  parameter int lock_timeout   = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*data_bits-1:0]    req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx_start,
  output logic [data_bits-1:0]            tx_data,
  input  logic                            tx_busy,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id,
  output logic                            grant_active,
  output logic                            lock_active,
  output logic                            accept_err
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int AW = cnt_width(accept_timeout);
  localparam int LW = cnt_width(lock_timeout);
  localparam logic [AW-1:0] ACK_LAST  = AW'(accept_timeout - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'((lock_timeout > 0) ? lock_timeout - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam bit            LOCK_RELEASE_EN = (lock_timeout != 0);

  uart_arb_state_t   state;
  logic [IW-1:0]     rr_ptr;
  logic              lock;
  logic [IW-1:0]     owner;
  logic [AW-1:0]     ack_timer;
  logic [LW-1:0]     lock_timer;

  logic [data_bits-1:0] req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]   owner_mask;
  logic [NUM_REQ-1:0]   elig;
  logic [IW-1:0]        pick_ptr;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 idle_free;
  logic                 handshake;
  logic                 pick_last;
  logic                 owner_valid;
  logic                 ack_expire;
  logic                 lock_expire;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*data_bits +: data_bits];
  end

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IW'(1);
  endfunction

  // Under a frame lock only the owner may compete, searched from its own slot.
  assign owner_mask  = NUM_REQ'(1) << owner;
  assign owner_valid = |(req_valid & owner_mask);
  assign elig        = lock ? (req_valid & owner_mask) : req_valid;
  assign pick_ptr    = lock ? owner : rr_ptr;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (elig),
    .rr_ptr    (pick_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign idle_free  = (state == ST_IDLE) && !tx_busy;
  assign req_ready  = idle_free ? pick_grant : '0;
  assign handshake  = idle_free && pick_any;
  assign pick_last  = |(req_last & pick_grant);

  assign ack_expire  = (state == ST_WAIT_ACK) && !tx_busy && (ack_timer == ACK_LAST);
  assign lock_expire = LOCK_RELEASE_EN && (state == ST_IDLE) && lock && !owner_valid
                       && (lock_timer == LOCK_LAST);

  assign tx_start     = (state == ST_LAUNCH);
  assign grant_active = (state == ST_LAUNCH) || (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);
  assign lock_active  = lock;
  assign accept_err   = ack_expire;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      lock       <= 1'b0;
      owner      <= '0;
      ack_timer  <= '0;
      lock_timer <= '0;
      tx_data    <= '0;
      grant_id   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            tx_data    <= req_bytes[pick_idx];
            grant_id   <= pick_idx;
            lock       <= !pick_last;
            lock_timer <= '0;
            if (!pick_last) owner <= pick_idx;
            state      <= ST_LAUNCH;
          end else if (lock_expire) begin
            lock       <= 1'b0;
            lock_timer <= '0;
            rr_ptr     <= next_idx(owner);
          end else if (LOCK_RELEASE_EN && lock && !owner_valid) begin
            lock_timer <= lock_timer + LW'(1);
          end
        end
        ST_LAUNCH: begin
          ack_timer <= '0;
          state     <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (ack_expire) begin
            // The transmitter never took the byte: drop it and any frame it began.
            lock      <= 1'b0;
            rr_ptr    <= next_idx(grant_id);
            ack_timer <= '0;
            state     <= ST_IDLE;
          end else begin
            ack_timer <= ack_timer + AW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (!lock) rr_ptr <= next_idx(grant_id);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester sources, a busy-flag
// transmitter model, and per-scenario tasks checking grant order and timing.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int DB       = 8;
  localparam int BUSY_LEN = 10;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       lock;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*DB-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic            tx_start;
  logic [DB-1:0]   tx_data;
  logic            tx_busy = 1'b0;
  logic [1:0]      grant_id;
  logic            grant_active;
  logic            lock_active;
  logic            accept_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t sb[$];
  src_t src_q[NREQ][$];
  bit   hs_pend[NREQ];
  int   rdy_cnt[NREQ];
  int   ga_cycles = 0;
  int   err_pulses = 0;
  int   err_delays[$];
  int   t_start = 0;
  bit   start_seen = 0;
  bit   model_ack = 1;
  int   busy_cnt = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ), .data_bits(DB), .accept_timeout(16), .lock_timeout(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .lock_active  (lock_active),
    .accept_err   (accept_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Requester sources: present the head of each queue, pop after a handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_pend[i]) begin
        if (src_q[i].size() > 0) src_q[i].delete(0);
        hs_pend[i] = 1'b0;
      end
      if (src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*DB +: DB]  = src_q[i][0].data;
        req_last[i]           = src_q[i][0].last;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DB +: DB]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  end

  // Transmitter model: busy rises right after the launch cycle and lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    #1;
    if (start_seen) begin
      start_seen = 1'b0;
      if (model_ack) begin
        tx_busy  = 1'b1;
        busy_cnt = BUSY_LEN;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) hs_pend[i] = 1'b1;
        if (req_ready[i]) rdy_cnt[i]++;
      end
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 || tx_busy) begin
          errors++;
          $display("FAIL ready_onehot: req_ready=%b tx_busy=%b, expected one-hot with busy low", req_ready, tx_busy);
        end
      end
      if (grant_active) ga_cycles++;
      if (accept_err) begin
        err_pulses++;
        err_delays.push_back(cyc - t_start);
      end
      if (tx_start) begin
        start_seen = 1'b1;
        t_start    = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected: tx_start with grant_id=%0d tx_data=%h, expected none", grant_id, tx_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (grant_id !== e.id || tx_data !== e.data || lock_active !== e.lock) begin
            errors++;
            $display("FAIL launch: got id=%0d data=%h lock=%b, expected id=%0d data=%h lock=%b",
                     grant_id, tx_data, lock_active, e.id, e.data, e.lock);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [7:0] data, input logic last);
    src_t s;
    s.data = data;
    s.last = last;
    src_q[i].push_back(s);
  endtask

  task automatic expect_byte(input logic [1:0] id, input logic [7:0] data, input logic lock);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.lock = lock;
    sb.push_back(e);
  endtask

  task automatic clear_counters();
    for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
    ga_cycles  = 0;
    err_pulses = 0;
    err_delays.delete();
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !grant_active && !tx_busy;
      for (int i = 0; i < NREQ; i++)
        if (src_q[i].size() != 0 || hs_pend[i]) done = 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: %0d launches still expected, expected all drained", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (tx_start !== 1'b0)     begin errors++; $display("FAIL reset_tx_start: got %b, expected 0", tx_start); end
    if (tx_data !== '0)        begin errors++; $display("FAIL reset_tx_data: got %h, expected 00", tx_data); end
    if (grant_id !== '0)       begin errors++; $display("FAIL reset_grant_id: got %0d, expected 0", grant_id); end
    if (grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant_active: got %b, expected 0", grant_active); end
    if (lock_active !== 1'b0)  begin errors++; $display("FAIL reset_lock_active: got %b, expected 0", lock_active); end
    if (accept_err !== 1'b0)   begin errors++; $display("FAIL reset_accept_err: got %b, expected 0", accept_err); end
    if (req_ready !== '0)      begin errors++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (grant_active !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: grant_active=%b tx_start=%b, expected 0 0", grant_active, tx_start);
    end
  endtask

  task automatic test_fairness();
    sync();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NREQ; i++) begin
        send(i, 8'(16*i + b), 1'b1);
        expect_byte(2'(i), 8'(16*i + b), 1'b0);
      end
    wait_idle("fairness");
  endtask

  task automatic test_single_byte();
    sync();
    clear_counters();
    send(2, 8'hA5, 1'b1);
    expect_byte(2'd2, 8'hA5, 1'b0);
    wait_idle("single");
    checks += 3;
    if (rdy_cnt[2] != 1)  begin errors++; $display("FAIL single_ready_pulses: got %0d, expected 1", rdy_cnt[2]); end
    if (ga_cycles != 12)  begin errors++; $display("FAIL single_grant_active_cycles: got %0d, expected 12", ga_cycles); end
    if (err_pulses != 0)  begin errors++; $display("FAIL single_accept_err: got %0d pulses, expected 0", err_pulses); end
    // Pointer now sits at 3: requester 3 must beat requester 0.
    sync();
    send(0, 8'h11, 1'b1);
    send(3, 8'h33, 1'b1);
    expect_byte(2'd3, 8'h33, 1'b0);
    expect_byte(2'd0, 8'h11, 1'b0);
    wait_idle("rr_after_single");
  endtask

  task automatic test_frame_lock();
    sync();
    send(1, 8'h10, 1'b0);
    send(1, 8'h11, 1'b0);
    send(1, 8'h12, 1'b1);
    send(0, 8'h20, 1'b1);
    send(3, 8'h30, 1'b1);
    expect_byte(2'd1, 8'h10, 1'b1);
    expect_byte(2'd1, 8'h11, 1'b1);
    expect_byte(2'd1, 8'h12, 1'b0);
    expect_byte(2'd3, 8'h30, 1'b0);
    expect_byte(2'd0, 8'h20, 1'b0);
    wait_idle("frame_lock");
  endtask

  task automatic test_accept_timeout();
    sync();
    clear_counters();
    model_ack = 1'b0;
    send(2, 8'h5A, 1'b1);
    send(3, 8'h6B, 1'b1);
    expect_byte(2'd2, 8'h5A, 1'b0);
    expect_byte(2'd3, 8'h6B, 1'b0);
    wait_idle("accept_timeout");
    model_ack = 1'b1;
    checks++;
    if (err_pulses != 2) begin errors++; $display("FAIL accept_err_pulses: got %0d, expected 2", err_pulses); end
    foreach (err_delays[k]) begin
      checks++;
      if (err_delays[k] != 16) begin
        errors++;
        $display("FAIL accept_err_delay: got %0d cycles after tx_start, expected 16", err_delays[k]);
      end
    end
  endtask

  task automatic test_lock_abandon();
    bit got_active = 0;
    bit got_idle = 0;
    bit got_rdy = 0;
    int t_idle = 0;
    int t_rdy = 0;
    logic lock_at_rdy = 1'b1;
    sync();
    send(0, 8'h40, 1'b0);
    send(2, 8'h42, 1'b1);
    expect_byte(2'd0, 8'h40, 1'b1);
    expect_byte(2'd2, 8'h42, 1'b0);
    for (int k = 0; k < 200 && !got_rdy; k++) begin
      @(negedge clk);
      if (!got_active) got_active = grant_active;
      else if (!got_idle && !grant_active) begin got_idle = 1; t_idle = cyc; end
      if (got_idle && req_ready[2]) begin got_rdy = 1; t_rdy = cyc; lock_at_rdy = lock_active; end
    end
    checks += 2;
    if (!got_rdy) begin
      errors++;
      $display("FAIL lock_abandon_ready: ready[2] never asserted, expected after 8 idle cycles");
    end else if (t_rdy - t_idle != 8) begin
      errors++;
      $display("FAIL lock_abandon_delay: ready[2] after %0d idle cycles, expected 8", t_rdy - t_idle);
    end
    if (lock_at_rdy !== 1'b0) begin
      errors++;
      $display("FAIL lock_abandon_release: lock_active=%b at ready[2], expected 0", lock_at_rdy);
    end
    wait_idle("lock_abandon");
  endtask

  task automatic test_reset_mid_byte();
    bit seen_busy = 0;
    sync();
    send(1, 8'h77, 1'b1);
    expect_byte(2'd1, 8'h77, 1'b0);
    for (int k = 0; k < 50 && !seen_busy; k++) begin
      @(negedge clk);
      seen_busy = tx_busy;
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks += 7;
    if (tx_start !== 1'b0)     begin errors++; $display("FAIL midreset_tx_start: got %b, expected 0", tx_start); end
    if (tx_data !== '0)        begin errors++; $display("FAIL midreset_tx_data: got %h, expected 00", tx_data); end
    if (grant_id !== '0)       begin errors++; $display("FAIL midreset_grant_id: got %0d, expected 0", grant_id); end
    if (grant_active !== 1'b0) begin errors++; $display("FAIL midreset_grant_active: got %b, expected 0", grant_active); end
    if (lock_active !== 1'b0)  begin errors++; $display("FAIL midreset_lock_active: got %b, expected 0", lock_active); end
    if (accept_err !== 1'b0)   begin errors++; $display("FAIL midreset_accept_err: got %b, expected 0", accept_err); end
    if (req_ready !== '0)      begin errors++; $display("FAIL midreset_req_ready: got %b, expected 0", req_ready); end
    send(3, 8'h33, 1'b1);
    expect_byte(2'd3, 8'h33, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!tx_busy) break;
      checks++;
      if (req_ready !== '0 || grant_active !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold: req_ready=%b grant_active=%b while busy, expected 0 0", req_ready, grant_active);
      end
    end
    wait_idle("reset_mid_byte");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached with %0d launches outstanding", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fairness();
    test_single_byte();
    test_frame_lock();
    test_accept_timeout();
    test_lock_abandon();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
